// File: rtl/seq_divider32_pkg.sv
// Shared types and defaults for the iterative divider: FSM state encoding and operand width.
// No logic; latency and backpressure are properties of the modules that import it.
package seq_divider32_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider32_sub_borrow.sv
// Combinational W-bit subtractor a - b as a + ~b + 1; borrow is the inverted carry-out.
// Zero latency, no handshake.
module seq_divider32_sub_borrow #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] sum;

    assign sum    = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    assign diff   = sum[W-1:0];
    assign borrow = ~sum[W];

endmodule

// File: rtl/seq_divider32.sv
// Restoring unsigned divider, one quotient bit per clock; latency WIDTH+1 (1 on divide-by-zero).
// Accepts only in IDLE; result held with out_valid until out_ready.
module seq_divider32
    import seq_divider32_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic             unused_trial_msb;

    // Shift in the next dividend bit; the extra top bit keeps the trial subtract exact
    // when the divisor MSB is set.
    assign r_shift = {rem_q, q_q[WIDTH-1]};

    seq_divider32_sub_borrow #(
        .W (WIDTH + 1)
    ) u_sub (
        .a      (r_shift),
        .b      ({1'b0, d_q}),
        .diff   (trial),
        .borrow (borrow)
    );

    // After a non-borrowing subtract the result is below the divisor, so its MSB is always 0.
    assign unused_trial_msb = trial[WIDTH];

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        q_d         = q_q;
        d_d         = d_q;
        count_d     = count_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    d_d        = divisor;
                    count_d    = '0;
                    in_ready_d = 1'b0;
                    if (divisor == '0) begin
                        q_d         = '1;
                        rem_d       = dividend;
                        dbz_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        q_d     = dividend;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                q_d     = {q_q[WIDTH-2:0], ~borrow};
                rem_d   = borrow ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
                count_d = count_q + CW'(1);
                if (count_q == CNT_LAST) begin
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            q_q         <= '0;
            d_q         <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            d_q         <= d_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = q_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider32.sv
// Randomised and directed bench for seq_divider32 against a plain-arithmetic reference.
// Inputs driven on negedge, outputs sampled on negedge.
module tb_seq_divider32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_divider32 #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // stall: cycles of out_ready=0 once the result is up; inject_at / abort_at: RUN cycle at
    // which to pulse a stray 9/3 request or assert reset (0 = never); exp_lat: 0 skips latency check.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall,
                          input int inject_at, input int abort_at, input int exp_lat);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        logic [63:0] recon;
        int          lat;

        if (b == 32'd0) begin
            eq = 32'hFFFF_FFFF; er = a; ez = 1'b1;
        end else begin
            eq = a / b; er = a % b; ez = 1'b0;
        end

        lat = 0;
        while (!in_ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!in_ready) begin
            check("wait_in_ready", {63'd0, in_ready}, 64'd1);
            return;
        end

        out_ready = (stall == 0);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat = 1;
        check("busy_in_ready", {63'd0, in_ready}, 64'd0);

        while (!out_valid && lat < 100) begin
            if (lat == inject_at) begin
                dividend = 32'd9;
                divisor  = 32'd3;
                in_valid = 1'b1;
            end
            if (lat == abort_at) rst = 1'b1;
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
            if (rst) begin
                rst = 1'b0;
                check("abort_out_valid", {63'd0, out_valid}, 64'd0);
                check("abort_in_ready", {63'd0, in_ready}, 64'd1);
                return;
            end
        end

        check("out_valid", {63'd0, out_valid}, 64'd1);
        if (exp_lat != 0) check("latency", 64'(lat), 64'(exp_lat));
        check("quotient", {32'd0, quotient}, {32'd0, eq});
        check("remainder", {32'd0, remainder}, {32'd0, er});
        check("div_by_zero", {63'd0, div_by_zero}, {63'd0, ez});
        if (!ez) begin
            recon = 64'(quotient) * 64'(b) + 64'(remainder);
            check("invariant", recon, {32'd0, a});
            check("rem_lt_div", {63'd0, (remainder < b)}, 64'd1);
        end

        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_quot", {32'd0, quotient}, {32'd0, eq});
            check("hold_rem", {32'd0, remainder}, {32'd0, er});
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", {63'd0, out_valid}, 64'd0);
        check("release_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_quotient", {32'd0, quotient}, 64'd0);
        check("rst_remainder", {32'd0, remainder}, 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'd100, 32'd7, 0, 0, 0, 33);
        run_op(32'hFFFF_FFFF, 32'd1, 0, 0, 0, 33);
        run_op(32'd5, 32'd9, 0, 0, 0, 33);
        run_op(32'h8000_0000, 32'h8000_0001, 0, 0, 0, 33);
        run_op(32'd1234, 32'd0, 0, 0, 0, 1);
        run_op(32'd100, 32'd7, 10, 0, 0, 33);
        run_op(32'd100, 32'd7, 0, 5, 0, 33);
        run_op(32'd77777, 32'd3, 0, 0, 16, 0);
        run_op(32'd50, 32'd5, 0, 0, 0, 33);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0, 33);

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = $urandom | 32'h8000_0000;
                3:       rb = ra >> $urandom_range(0, 31);
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(ra, rb, $urandom_range(0, 2), 0, 0, (rb == 32'd0) ? 1 : 33);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
